pport_pc: RTL

Next-generation AVR parallel port for the I/O space. It provides PORTX, DDRX and PINX for 1–8 pins and adds three things:
- a parametrised input synchroniser,
- AVR-style PINX-write toggle of PORTX,
- a pin-change interrupt with mask, selectable edge mode, sticky flag and an `irq`/`irqack` handshake to the core's interrupt controller.

It sits on the core's 6-bit I/O bus beside the other I/O peripherals.

---
 rtl/pport_pc_pkg.sv | 23 ++
 rtl/pport_sync.sv | 25 ++
 rtl/pport_pc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pport_pc_pkg.sv
// Shared constants for the pin-change parallel port: edge-mode encodings,
// PCCR bit positions and the implemented-pin mask helper.
package pport_pc_pkg;

  localparam logic [1:0] c_em_any  = 2'b00;
  localparam logic [1:0] c_em_rise = 2'b01;
  localparam logic [1:0] c_em_fall = 2'b10;

  localparam int c_pcie_bit  = 0;
  localparam int c_emode_lsb = 1;
  localparam int c_pcif_bit  = 7;

  // Ones in the low 'width' bit positions; bits above the pin count read 0.
  function automatic logic [7:0] impl_mask(input int width);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pport_sync.sv
// Multi-stage input synchroniser for the asynchronous pin inputs.
module pport_sync #(
  parameter int port_width  = 8,
  parameter int sync_stages = 2
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic [port_width-1:0] d,
  output logic [port_width-1:0] q
);

  logic [port_width-1:0] stage [sync_stages];

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < sync_stages; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < sync_stages; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[sync_stages-1];

endmodule

// File: rtl/pport_pc.sv
// AVR-style parallel port with PINX-write toggle and a maskable pin-change
// interrupt (edge mode, sticky PCIF, irq/irqack handshake).
module pport_pc
  import pport_pc_pkg::*;
#(
  parameter logic [5:0] portx_adr   = 6'd0,
  parameter logic [5:0] ddrx_adr    = 6'd1,
  parameter logic [5:0] pinx_adr    = 6'd2,
  parameter logic [5:0] pcmsk_adr   = 6'd3,
  parameter logic [5:0] pccr_adr    = 6'd4,
  parameter int         port_width  = 8,
  parameter int         sync_stages = 2
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic [5:0]            adr,
  input  logic [7:0]            dbus_in,
  output logic [7:0]            dbus_out,
  input  logic                  iore,
  input  logic                  iowe,
  output logic                  io_out_en,
  output logic [port_width-1:0] portx,
  output logic [port_width-1:0] ddrx,
  input  logic [port_width-1:0] pinx,
  output logic [port_width-1:0] resync_out,
  output logic                  irq,
  input  logic                  irqack
);

  localparam logic [7:0] c_mask    = impl_mask(port_width);
  localparam logic [2:0] c_arm_max = 3'(sync_stages + 1);

  logic [7:0]            portx_r, ddrx_r, pcmsk_r;
  logic                  pcie_r, pcif_r;
  logic [1:0]            emode_r;
  logic [port_width-1:0] prev_r;
  logic [2:0]            arm_cnt;

  logic sel_port, sel_ddr, sel_pin, sel_msk, sel_pccr;
  logic wr_port, wr_ddr, wr_pin, wr_msk, wr_pccr;
  logic [port_width-1:0] edg, evt;
  logic armed, pc_set;
  logic [7:0] rs8, pccr_rd, rd;

  pport_sync #(
    .port_width (port_width),
    .sync_stages(sync_stages)
  ) u_sync (
    .cp2   (cp2),
    .ireset(ireset),
    .d     (pinx),
    .q     (resync_out)
  );

  assign sel_port  = (adr == portx_adr);
  assign sel_ddr   = (adr == ddrx_adr);
  assign sel_pin   = (adr == pinx_adr);
  assign sel_msk   = (adr == pcmsk_adr);
  assign sel_pccr  = (adr == pccr_adr);
  assign io_out_en = iore & (sel_port | sel_ddr | sel_pin | sel_msk | sel_pccr);

  assign wr_port = iowe & sel_port;
  assign wr_ddr  = iowe & sel_ddr;
  assign wr_pin  = iowe & sel_pin;
  assign wr_msk  = iowe & sel_msk;
  assign wr_pccr = iowe & sel_pccr;

  always_comb begin
    case (emode_r)
      c_em_rise: edg = ~prev_r & resync_out;
      c_em_fall: edg = prev_r & ~resync_out;
      default:   edg = prev_r ^ resync_out;
    endcase
  end

  // Detection stays off until the synchroniser has flushed post-reset values.
  assign evt    = edg & pcmsk_r[port_width-1:0];
  assign armed  = (arm_cnt == c_arm_max);
  assign pc_set = armed & (|evt);

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      portx_r <= '0;
      ddrx_r  <= '0;
      pcmsk_r <= '0;
      pcie_r  <= 1'b0;
      emode_r <= c_em_any;
      pcif_r  <= 1'b0;
      prev_r  <= '0;
      arm_cnt <= '0;
    end else begin
      if (wr_port)     portx_r <= dbus_in & c_mask;
      else if (wr_pin) portx_r <= portx_r ^ (dbus_in & c_mask);
      if (wr_ddr)      ddrx_r  <= dbus_in & c_mask;
      if (wr_msk)      pcmsk_r <= dbus_in & c_mask;
      if (wr_pccr) begin
        pcie_r  <= dbus_in[c_pcie_bit];
        emode_r <= dbus_in[c_emode_lsb +: 2];
      end
      // A fresh event wins over acknowledge and software clear.
      if (pc_set)
        pcif_r <= 1'b1;
      else if (irqack | (wr_pccr & dbus_in[c_pcif_bit]))
        pcif_r <= 1'b0;
      prev_r <= resync_out;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  always_comb begin
    rs8 = '0;
    rs8[port_width-1:0] = resync_out;
    pccr_rd = '0;
    pccr_rd[c_pcie_bit] = pcie_r;
    pccr_rd[c_emode_lsb +: 2] = emode_r;
    pccr_rd[c_pcif_bit] = pcif_r;
  end

  always_comb begin
    rd = '0;
    if (sel_port)      rd = portx_r;
    else if (sel_ddr)  rd = ddrx_r;
    else if (sel_pin)  rd = rs8;
    else if (sel_msk)  rd = pcmsk_r;
    else if (sel_pccr) rd = pccr_rd;
  end

  assign dbus_out = io_out_en ? rd : 8'h00;

  // irq is a level held until the controller answers with a one-cycle irqack;
  // the ack clears PCIF on that edge unless a new event lands in the same cycle.
  assign irq   = pcif_r & pcie_r;
  assign portx = portx_r[port_width-1:0];
  assign ddrx  = ddrx_r[port_width-1:0];

endmodule
